// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit framing controller.
//
// Accepts a byte on a valid/ready handshake, loads it into an external
// 8-bit PISO and walks the frame: start bit, 8 data bits LSB first (taken
// from the PISO serial output), optional parity bit, then 1 or 2 stop bits.
// Every bit lasts CLKS_PER_BIT clocks. The serial line is registered, so
// it lags the state by exactly one clock and is glitch-free.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   tx_valid   upstream has a byte on tx_data
//   tx_data    byte to transmit
//   tx_ready   controller can accept a byte this cycle
//   piso_load  load strobe to the PISO (same cycle as the handshake)
//   piso_shift right-shift strobe to the PISO (bit-end of each data bit)
//   piso_data  parallel data to the PISO (tx_data passed through)
//   piso_bit   PISO serial output (its bit 0)
//   tx         serial line, idle high
//   tx_busy    a frame is in progress
//   tx_done    one-cycle pulse in the final stop-bit cycle
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       piso_load,
  output logic       piso_shift,
  output logic [7:0] piso_data,
  input  logic       piso_bit,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BCNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  // Stop-bit index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [BCNT_W-1:0] bcnt_q;
  logic [2:0]        bit_idx_q;
  logic              stop_idx_q;
  logic              par_q;
  logic              line;
  logic              bit_end;

  assign bit_end   = (bcnt_q == BCNT_LAST);
  assign piso_data = tx_data;
  assign tx_busy   = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    line       = 1'b1;
    tx_ready   = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    tx_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rst is folded in so ready/load stay low for the whole reset pulse.
        tx_ready  = ~rst;
        piso_load = tx_valid & ~rst;
        if (tx_valid && !rst) begin
          state_d = S_START;
        end
      end
      S_START: begin
        line = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        line = piso_bit;
        // Shift on the bit-end edge so the PISO advances with bit_idx_q.
        if (bit_end) begin
          piso_shift = 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        line = par_q;
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        line = 1'b1;
        if (bit_end && (stop_idx_q == STOP_LAST)) begin
          tx_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state_q <= state_d;
      tx      <= line;
      // Baud counter wraps at each bit end and restarts on every state change.
      if ((state_d != state_q) || (state_q == S_IDLE) || bit_end) begin
        bcnt_q <= '0;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
      if (state_q != S_DATA) begin
        bit_idx_q <= '0;
      end else if (bit_end) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (state_q != S_STOP) begin
        stop_idx_q <= 1'b0;
      end else if (bit_end) begin
        stop_idx_q <= ~stop_idx_q;
      end
      // Parity is captured at the handshake; tx_data need not be held after.
      if (piso_load) begin
        par_q <= (^tx_data) ^ PAR_INV;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances with CLKS_PER_BIT=4 in different
// framing configurations, each driving its own behavioural PISO.
//   inst0: no parity, 1 stop   inst1: even parity, 1 stop
//   inst2: odd parity, 1 stop  inst3: no parity, 2 stop
module tb_uart_tx_ctrl;

  localparam int CPB      = 4;
  localparam int NI       = 4;
  localparam int IDLE_POS = 100000;
  localparam int PE_A [NI] = '{0, 1, 1, 0};
  localparam int PO_A [NI] = '{0, 0, 1, 0};
  localparam int SB_A [NI] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vld   [NI];
  logic [7:0] dat   [NI];
  logic       rdy   [NI];
  logic       load  [NI];
  logic       shift [NI];
  logic [7:0] pdata [NI];
  logic       pbit  [NI];
  logic       txl   [NI];
  logic       busy  [NI];
  logic       done  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [7:0] piso_q;

    uart_tx_ctrl #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE_A[g]),
      .PARITY_ODD  (PO_A[g]),
      .STOP_BITS   (SB_A[g])
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_valid  (vld[g]),
      .tx_data   (dat[g]),
      .tx_ready  (rdy[g]),
      .piso_load (load[g]),
      .piso_shift(shift[g]),
      .piso_data (pdata[g]),
      .piso_bit  (pbit[g]),
      .tx        (txl[g]),
      .tx_busy   (busy[g]),
      .tx_done   (done[g])
    );

    always @(posedge clk) begin
      if (load[g]) piso_q <= pdata[g];
      else if (shift[g]) piso_q <= {1'b0, piso_q[7:1]};
    end
    assign pbit[g] = piso_q[0];
  end

  int tests = 0;
  int fails = 0;

  // Frame length in clocks and the frame bits in line order (bit 0 first).
  function automatic int flen(int i);
    return (9 + PE_A[i] + SB_A[i]) * CPB;
  endfunction

  function automatic logic [11:0] frame_of(int i, logic [7:0] d);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (PE_A[i] != 0) f[9] = (^d) ^ (PO_A[i] != 0);
    return f;
  endfunction

  // Reference model: clocks elapsed since the accepting edge of the current
  // frame, plus the bit pattern of that frame.
  int          lpos  [NI];
  logic [11:0] fbits [NI];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        lpos[i] <= IDLE_POS;
      end else if (vld[i] && (lpos[i] >= flen(i))) begin
        lpos[i]  <= 0;
        fbits[i] <= frame_of(i, dat[i]);
      end else if (lpos[i] < IDLE_POS) begin
        lpos[i] <= lpos[i] + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Advance to the next falling edge and compare every instance with the model.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int n;
      logic eb, er, et, es;
      logic [5:0] g, e;
      n  = flen(i);
      eb = lpos[i] < n;
      er = !eb && !rst;
      et = (lpos[i] >= 1 && lpos[i] <= n) ? fbits[i][(lpos[i] - 1) / CPB] : 1'b1;
      es = (lpos[i] >= CPB) && (lpos[i] < 9 * CPB) && ((lpos[i] % CPB) == CPB - 1);
      e  = {et, eb, er, (lpos[i] == n - 1), (vld[i] && er), es};
      g  = {txl[i], busy[i], rdy[i], done[i], load[i], shift[i]};
      tests++;
      if (g !== e) begin
        fails++;
        if (fails <= 40)
          $display("FAIL model inst%0d t=%0t: got tx,busy,rdy,done,load,shift=%b want %b",
                   i, $time, g, e);
      end
    end
  endtask

  task automatic wait_idle(input int i);
    int w;
    w = 0;
    while (!rdy[i] && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout inst%0d: got busy want ready within 200 clks", i);
    end
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [11:0] bits;
    int          nbits;
    int          len;
  } vec_t;

  task automatic check_frame(input vec_t v);
    int i, busy_n, shifts, dones, loads;
    logic [11:0] got, mask;
    logic t0, t1;
    i = v.inst;
    busy_n = 0; shifts = 0; dones = 0; loads = 0;
    got = '1; t0 = 1'b0; t1 = 1'b1;
    wait_idle(i);
    vld[i] = 1'b1;
    dat[i] = v.data;
    #1;
    check("load_strobe", 32'(load[i]), 32'd1);
    check("piso_data", 32'(pdata[i]), 32'(v.data));
    tick();
    vld[i] = 1'b0;
    dat[i] = 8'($urandom);
    for (int c = 0; c <= v.len + 1; c++) begin
      if (c == 0) t0 = txl[i];
      if (c == 1) t1 = txl[i];
      if (c >= 1 && ((c - 1) % CPB) == CPB / 2 && ((c - 1) / CPB) < 12)
        got[(c - 1) / CPB] = txl[i];
      busy_n += int'(busy[i]);
      shifts += int'(shift[i]);
      dones  += int'(done[i]);
      loads  += int'(load[i]);
      tick();
    end
    mask = (12'h1 << v.nbits) - 12'h1;
    check("frame_bits", 32'(got & mask), 32'(v.bits));
    check("start_latency", 32'({t0, t1}), 32'b10);
    check("frame_len", 32'(busy_n), 32'(v.len));
    check("shift_count", 32'(shifts), 32'd8);
    check("done_count", 32'(dones), 32'd1);
    check("load_in_frame", 32'(loads), 32'd0);
  endtask

  vec_t vt [5];
  vec_t v7;

  initial begin
    int n0, gap, fall, bl;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end
    vt[0] = '{0, 8'hA5, 12'h34A, 10, 40};
    vt[1] = '{1, 8'h07, 12'h60E, 11, 44};
    vt[2] = '{2, 8'h00, 12'h600, 11, 44};
    vt[3] = '{2, 8'hFF, 12'h7FE, 11, 44};
    vt[4] = '{3, 8'h00, 12'h600, 11, 44};

    // Reset state.
    repeat (3) tick();
    check("reset_tx", 32'(txl[0]), 32'd1);
    check("reset_ready", 32'(rdy[0]), 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) check_frame(vt[k]);

    // Back-to-back frames with tx_valid held high.
    wait_idle(0);
    n0 = flen(0);
    gap = -1; fall = -1; bl = 0;
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    tick();
    dat[0] = 8'h33;
    for (int c = 0; c < n0 + 8; c++) begin
      if (c > 0 && c < n0) bl += int'(load[0]);
      if (c > 0 && load[0] && gap < 0) gap = c;
      if (gap >= 0 && c > gap && !txl[0] && fall < 0) fall = c;
      tick();
      if (c == gap) vld[0] = 1'b0;
    end
    vld[0] = 1'b0;
    check("b2b_busy_loads", 32'(bl), 32'd0);
    check("b2b_load_gap", 32'(gap), 32'(n0));
    check("b2b_start_fall", 32'(fall), 32'(n0 + 2));
    wait_idle(0);

    // Reset in the middle of data bit 3, then a clean frame.
    vld[0] = 1'b1;
    dat[0] = 8'hFF;
    tick();
    vld[0] = 1'b0;
    repeat (17) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", 32'(txl[0]), 32'd1);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_ready", 32'(rdy[0]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    v7 = '{0, 8'h3C, 12'h278, 10, 40};
    check_frame(v7);

    // Randomised traffic on all instances against the model.
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NI; i++) begin
        vld[i] = ($urandom_range(0, 9) < 7);
        dat[i] = 8'($urandom);
      end
      tick();
    end
    for (int i = 0; i < NI; i++) vld[i] = 1'b0;
    for (int i = 0; i < NI; i++) wait_idle(i);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit framing controller for the UART TX path.
- Accepts a byte over a valid/ready handshake and generates baud timing.
- Drives the load/shift controls of the 8-bit TX PISO shift register and consumes its serial output bit.
- Emits the framed serial line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal values >= 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  upstream has a byte on tx_data.
- tx_data  input  8  byte to transmit.
- tx_ready  output  1  controller can accept a byte this cycle.
- piso_load  output  1  load strobe to the PISO.
- piso_shift  output  1  right-shift strobe to the PISO.
- piso_data  output  8  parallel data to the PISO.
- piso_bit  input  1  PISO serial output (its bit 0).
- tx  output  1  serial line; idle high.
- tx_busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is asserted:
  - tx=1, tx_ready=0, tx_busy=0, tx_done=0, piso_load=0, piso_shift=0.
  - State=IDLE; baud counter, bit index and parity register are cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- Baud counter bcnt runs 0..CLKS_PER_BIT-1 in every non-IDLE state and clears on each state change. "Bit end" means bcnt==CLKS_PER_BIT-1.
- IDLE:
  - tx_ready=1.
  - Handshake = tx_valid & tx_ready, sampled at rising edge E0.
  - piso_load=tx_valid & tx_ready (combinational); piso_data=tx_data (combinational).
  - At E0: capture parity = ^tx_data, inverted if PARITY_ODD; state goes to START.
  - tx_valid while not ready is ignored; tx_data need not be held after E0.
- START: line value 0 for CLKS_PER_BIT cycles. At bit end: go to DATA with bit index 0.
- DATA:
  - Line value = piso_bit.
  - piso_shift=1 exactly during the bit-end cycle of each of the 8 bits, so the PISO advances on the same edge the bit index increments.
  - After the bit end with bit index 7: go to PARITY if PARITY_EN, else to STOP.
- PARITY: line value = captured parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - Line value 1 for STOP_BITS*CLKS_PER_BIT cycles, counted with a stop-bit index.
  - In the final cycle: tx_done=1; next state IDLE.
- Line register: tx is a register loaded every clk with the combinational line value (1 in IDLE). tx therefore lags state by exactly one clock, is glitch-free, and every bit on tx lasts exactly CLKS_PER_BIT clocks.
- Latency: tx falls at edge E0+1.
- Frame length on tx: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT clocks.
- tx_busy = (state != IDLE).
- piso_load and piso_shift are never asserted in the same cycle.
- Back-to-back frames:
  - tx_ready rises in the cycle after the final stop cycle.
  - With tx_valid held high, the next frame's start bit follows the previous stop bit(s) with no extra high time beyond one clock.
- Reset mid-frame: all outputs take their reset values immediately (tx=1). After release the controller sits in IDLE; no partial frame resumes.

Test Plan:
1. CLKS_PER_BIT=4, no parity, STOP_BITS=1; send 0xA5.
   -> tx low from E0+1 for 4 clks, then data 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks.
   -> 40-clk frame; 8 piso_shift pulses spaced 4 clks apart; piso_load pulses once at E0; tx_done pulses once.
2. PARITY_EN=1, PARITY_ODD=0; send 0x07. -> parity bit 1 after the data bits; frame 44 clks.
3. PARITY_EN=1, PARITY_ODD=1; send 0x00. -> parity bit 1.
4. PARITY_EN=1, PARITY_ODD=1; send 0xFF. -> parity bit 1.
5. STOP_BITS=2; send 0x00. -> 8 high clks after the data; tx_done in the last of them.
6. tx_valid held high with 0x55 then 0x33.
   -> two frames, second start bit 1 clk after the first frame's stop ends.
   -> tx_valid during busy produces no piso_load.
7. Assert rst during DATA bit 3. -> tx=1, tx_busy=0 immediately.
   -> After release, a new 0x3C frame is transmitted correctly with no residue of the aborted byte.
